// File: rtl/mvu_seq.sv
// mvu_seq: job sequencer for the bit-serial matrix-vector unit.
// Takes one job (weight/activation base, tiles per bit-plane, precisions,
// signedness). For each bit-plane pair it issues one weight/activation read
// address pair per cycle, most significant pairs first, plus the
// mulmode/clr/sh controls that let the MVU shift-accumulators build the
// full-precision dot products.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   job request, only taken while busy=0
//   wbase, abase, len       base addresses, tiles per bit-plane (0 means 1)
//   wprec, aprec            operand bits minus one
//   wsigned, asigned        two's-complement operands
//   busy, done              job in progress / final result valid on O
//   Raddr, Aaddr            weight / activation read address (0 when idle)
//   mulmode                 {w sign-plane, a sign-plane}, aligned to W/D
//   clr, sh                 accumulator load / shift-add, aligned to S
// RLAT and PLAT must both be at least 1.
module mvu_seq #(
   parameter int RLAT = 1,
   parameter int PLAT = 2,
   parameter int AW   = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] wbase,
   input  logic [AW-1:0] abase,
   input  logic [AW-1:0] len,
   input  logic [3:0]    wprec,
   input  logic [3:0]    aprec,
   input  logic          wsigned,
   input  logic          asigned,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] Raddr,
   output logic [AW-1:0] Aaddr,
   output logic [1:0]    mulmode,
   output logic          clr,
   output logic          sh
);
   localparam int DLAT = RLAT + PLAT;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wbase_q, wbase_d, abase_q, abase_d, len_q, len_d, t_q, t_d;
   logic [3:0]    wmax_q, wmax_d, amax_q, amax_d, j_q, j_d;
   logic [4:0]    s_q, s_d;
   logic          ws_q, ws_d, as_q, as_d, first_q, first_d;
   logic [RLAT-1:0][1:0] mm_pipe_q, mm_pipe_d;
   logic [DLAT-1:0][1:0] fl_pipe_q, fl_pipe_d;   // {clr, sh}
   logic [DLAT:0]        vld_pipe_q, vld_pipe_d; // last-issue marker

   // Highest / lowest weight plane index contributing to significance s.
   function automatic logic [3:0] jmax_f(input logic [4:0] s, input logic [3:0] wm);
      return (s > {1'b0, wm}) ? wm : s[3:0];
   endfunction

   function automatic logic [3:0] jmin_f(input logic [4:0] s, input logic [3:0] am);
      logic [4:0] diff;
      diff = s - {1'b0, am};
      return (s > {1'b0, am}) ? diff[3:0] : 4'd0;
   endfunction

   logic       issue, t_last, j_last, last_iss, clr_iss, sh_iss;
   logic [3:0] i_cur;
   logic [1:0] mm_iss;

   always_comb begin
      issue    = (state_q == S_RUN);
      // i = s - j always fits in 4 bits, so the low bits are exact.
      i_cur    = s_q[3:0] - j_q;
      t_last   = (t_q == len_q - AW'(1));
      j_last   = (j_q == jmin_f(s_q, amax_q));
      last_iss = issue && t_last && j_last && (s_q == 5'd0);
      clr_iss  = issue && first_q;
      sh_iss   = issue && !first_q && (t_q == '0) && (j_q == jmax_f(s_q, wmax_q));
      mm_iss   = issue ? {ws_q && (j_q == wmax_q), as_q && (i_cur == amax_q)} : 2'b00;
      Raddr    = issue ? wbase_q + AW'(j_q) * len_q + t_q : '0;
      Aaddr    = issue ? abase_q + AW'(i_cur) * len_q + t_q : '0;
      busy     = (state_q != S_IDLE);
      done     = vld_pipe_q[DLAT];
      mulmode  = mm_pipe_q[RLAT-1];
      clr      = fl_pipe_q[DLAT-1][1];
      sh       = fl_pipe_q[DLAT-1][0];
   end

   always_comb begin
      state_d = state_q;
      wbase_d = wbase_q;
      abase_d = abase_q;
      len_d   = len_q;
      wmax_d  = wmax_q;
      amax_d  = amax_q;
      ws_d    = ws_q;
      as_d    = as_q;
      s_d     = s_q;
      j_d     = j_q;
      t_d     = t_q;
      first_d = first_q;
      unique case (state_q)
         S_IDLE: if (start) begin
            state_d = S_RUN;
            wbase_d = wbase;
            abase_d = abase;
            len_d   = (len == '0) ? AW'(1) : len;
            wmax_d  = wprec;
            amax_d  = aprec;
            ws_d    = wsigned;
            as_d    = asigned;
            s_d     = {1'b0, wprec} + {1'b0, aprec};
            j_d     = wprec;  // jmax at the top significance
            t_d     = '0;
            first_d = 1'b1;
         end
         S_RUN: begin
            first_d = 1'b0;
            if (!t_last) begin
               t_d = t_q + AW'(1);
            end else begin
               t_d = '0;
               if (!j_last) begin
                  j_d = j_q - 4'd1;
               end else if (s_q == 5'd0) begin
                  state_d = S_DRAIN;
               end else begin
                  s_d = s_q - 5'd1;
                  j_d = jmax_f(s_q - 5'd1, wmax_q);
               end
            end
         end
         S_DRAIN: if (done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Delay lines; inputs are already zero outside valid issues.
   always_comb begin
      mm_pipe_d     = mm_pipe_q;
      fl_pipe_d     = fl_pipe_q;
      vld_pipe_d    = vld_pipe_q;
      mm_pipe_d[0]  = mm_iss;
      fl_pipe_d[0]  = {clr_iss, sh_iss};
      vld_pipe_d[0] = last_iss;
      for (int k = 1; k < RLAT; k++) mm_pipe_d[k] = mm_pipe_q[k-1];
      for (int k = 1; k < DLAT; k++) fl_pipe_d[k] = fl_pipe_q[k-1];
      for (int k = 1; k <= DLAT; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wbase_q    <= '0;
         abase_q    <= '0;
         len_q      <= '0;
         wmax_q     <= '0;
         amax_q     <= '0;
         ws_q       <= 1'b0;
         as_q       <= 1'b0;
         s_q        <= '0;
         j_q        <= '0;
         t_q        <= '0;
         first_q    <= 1'b0;
         mm_pipe_q  <= '0;
         fl_pipe_q  <= '0;
         vld_pipe_q <= '0;
      end else begin
         state_q    <= state_d;
         wbase_q    <= wbase_d;
         abase_q    <= abase_d;
         len_q      <= len_d;
         wmax_q     <= wmax_d;
         amax_q     <= amax_d;
         ws_q       <= ws_d;
         as_q       <= as_d;
         s_q        <= s_d;
         j_q        <= j_d;
         t_q        <= t_d;
         first_q    <= first_d;
         mm_pipe_q  <= mm_pipe_d;
         fl_pipe_q  <= fl_pipe_d;
         vld_pipe_q <= vld_pipe_d;
      end
   end
endmodule
